lsu: RTL and testbench

- Load/store unit directly downstream of the execute-stage ALU.
- Consumes the ALU result and computed memory address for one instruction at a time.
- Issues at most one request on the data-SRAM-like bus, then aligns and extends load data.
- Hands a registered result to write-back; non-memory instructions pass through with one cycle of latency.

---
 rtl/lsu_pkg.sv | 40 ++++
 rtl/lsu_align.sv | 69 ++++++
 rtl/lsu.sv | 155 +++++++++++++++
 tb/tb_lsu.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: memory op encoding, bus size codes
// and the controller state enum.
package lsu_pkg;

  typedef enum logic [3:0] {
    NONE  = 4'd0,
    LD_B  = 4'd1,
    LD_BU = 4'd2,
    LD_H  = 4'd3,
    LD_HU = 4'd4,
    LD_W  = 4'd5,
    ST_B  = 4'd6,
    ST_H  = 4'd7,
    ST_W  = 4'd8
  } mem_op_t;

  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT    = 2'd2,
    DISCARD = 2'd3
  } lsu_state_t;

  function automatic logic is_store(mem_op_t op);
    return (op == ST_B) || (op == ST_H) || (op == ST_W);
  endfunction

  function automatic logic [1:0] op_size(mem_op_t op);
    case (op)
      LD_B, LD_BU, ST_B: op_size = MEM_SIZE_B;
      LD_H, LD_HU, ST_H: op_size = MEM_SIZE_H;
      default:           op_size = MEM_SIZE_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store-side size/strobe/replication/misalign
// check, and load-side byte-lane extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        st_op,
  input  logic [1:0]        st_addr_lo,
  input  logic [DATA_W-1:0] st_wdata,
  output logic [1:0]        st_size,
  output logic [3:0]        st_wstrb,
  output logic [DATA_W-1:0] st_wdata_rep,
  output logic              misaligned,
  input  logic [3:0]        ld_op,
  input  logic [1:0]        ld_addr_lo,
  input  logic [DATA_W-1:0] ld_rdata,
  output logic [DATA_W-1:0] ld_result
);

  mem_op_t st_op_e;
  mem_op_t ld_op_e;
  logic [DATA_W-1:0] shifted;

  assign st_op_e = mem_op_t'(st_op);
  assign ld_op_e = mem_op_t'(ld_op);
  assign shifted = ld_rdata >> {ld_addr_lo, 3'b000};

  always_comb begin
    st_size      = op_size(st_op_e);
    st_wstrb     = 4'b1111;
    st_wdata_rep = st_wdata;
    misaligned   = 1'b0;
    case (st_op_e)
      LD_B, LD_BU, ST_B: begin
        st_wstrb     = 4'b0001 << st_addr_lo;
        st_wdata_rep = {4{st_wdata[7:0]}};
      end
      LD_H, LD_HU, ST_H: begin
        st_wstrb     = 4'b0011 << st_addr_lo;
        st_wdata_rep = {2{st_wdata[15:0]}};
        misaligned   = st_addr_lo[0];
      end
      LD_W, ST_W: misaligned = |st_addr_lo;
      default: ;
    endcase
  end

  logic signed [7:0]        byte_s;
  logic signed [15:0]       half_s;
  logic signed [DATA_W-1:0] ext_s;

  // Signed narrow values widen by sign extension on assignment.
  always_comb begin
    byte_s = shifted[7:0];
    half_s = shifted[15:0];
    ext_s  = '0;
    case (ld_op_e)
      LD_B:    ext_s = byte_s;
      LD_H:    ext_s = half_s;
      LD_BU:   ext_s = {{(DATA_W-8){1'b0}}, shifted[7:0]};
      LD_HU:   ext_s = {{(DATA_W-16){1'b0}}, shifted[15:0]};
      LD_W:    ext_s = ld_rdata;
      default: ext_s = '0;
    endcase
    ld_result = ext_s;
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one instruction from EX, performs at most one
// bus transaction and returns a registered write-back result.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [3:0]        ex_memop,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_aluout,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [4:0]        ex_rd,
  input  logic              ex_we,
  input  logic              flush,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [3:0]        data_wstrb,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_result,
  output logic [4:0]        wb_rd,
  output logic              wb_we,
  output logic              wb_ale,
  output logic [ADDR_W-1:0] wb_badv
);

  lsu_state_t state;
  mem_op_t    ex_op;
  logic       accept;

  logic [1:0]        st_size;
  logic [3:0]        st_wstrb;
  logic [DATA_W-1:0] st_wdata_rep;
  logic              misaligned;
  logic [DATA_W-1:0] ld_result;

  mem_op_t           op_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [4:0]        rd_p0;
  logic              we_p0;
  logic [1:0]        size_p0;
  logic [3:0]        wstrb_p0;
  logic [DATA_W-1:0] wdata_p0;

  assign ex_op    = mem_op_t'(ex_memop);
  assign ex_ready = (state == IDLE);
  assign accept   = ex_valid & ex_ready & ~flush;

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .st_op        (ex_memop),
    .st_addr_lo   (ex_addr[1:0]),
    .st_wdata     (ex_wdata),
    .st_size      (st_size),
    .st_wstrb     (st_wstrb),
    .st_wdata_rep (st_wdata_rep),
    .misaligned   (misaligned),
    .ld_op        (op_p0),
    .ld_addr_lo   (addr_p0[1:0]),
    .ld_rdata     (data_rdata),
    .ld_result    (ld_result)
  );

  // Stage p0: operands captured on acceptance, held for the whole transaction.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0    <= ex_op;
      addr_p0  <= ex_addr;
      rd_p0    <= ex_rd;
      we_p0    <= ex_we;
      size_p0  <= st_size;
      wstrb_p0 <= st_wstrb;
      wdata_p0 <= st_wdata_rep;
    end
  end

  // Bus outputs are gated by REQ so they read zero whenever no request is live.
  assign data_req   = (state == REQ);
  assign data_wr    = data_req & is_store(op_p0);
  assign data_size  = data_req ? size_p0 : 2'd0;
  assign data_addr  = data_req ? addr_p0 : '0;
  assign data_wstrb = data_wr ? wstrb_p0 : 4'd0;
  assign data_wdata = data_wr ? wdata_p0 : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wb_valid  <= 1'b0;
      wb_result <= '0;
      wb_rd     <= '0;
      wb_we     <= 1'b0;
      wb_ale    <= 1'b0;
      wb_badv   <= '0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (ex_op == NONE) begin
              wb_valid  <= 1'b1;
              wb_result <= ex_aluout;
              wb_rd     <= ex_rd;
              wb_we     <= ex_we;
              wb_ale    <= 1'b0;
              wb_badv   <= '0;
            end else if (misaligned) begin
              wb_valid  <= 1'b1;
              wb_result <= '0;
              wb_rd     <= ex_rd;
              wb_we     <= 1'b0;
              wb_ale    <= 1'b1;
              wb_badv   <= ex_addr;
            end else begin
              state <= REQ;
            end
          end
        end
        REQ: begin
          if (flush) state <= data_addr_ok ? DISCARD : IDLE;
          else if (data_addr_ok) state <= WAIT;
        end
        WAIT: begin
          // A flush coinciding with data_ok has nothing left to drain.
          if (data_data_ok) begin
            state <= IDLE;
            if (!flush) begin
              wb_valid  <= 1'b1;
              wb_result <= is_store(op_p0) ? '0 : ld_result;
              wb_rd     <= rd_p0;
              wb_we     <= we_p0 & ~is_store(op_p0);
              wb_ale    <= 1'b0;
              wb_badv   <= '0;
            end
          end else if (flush) begin
            state <= DISCARD;
          end
        end
        DISCARD: begin
          if (data_data_ok) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Randomized scoreboard bench for lsu with directed flush and reset cases.
module tb_lsu;
  import lsu_pkg::*;

  logic        clk;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  logic [3:0]  ex_memop;
  logic [31:0] ex_addr;
  logic [31:0] ex_aluout;
  logic [31:0] ex_wdata;
  logic [4:0]  ex_rd;
  logic        ex_we;
  logic        flush;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        wb_valid;
  logic [31:0] wb_result;
  logic [4:0]  wb_rd;
  logic        wb_we;
  logic        wb_ale;
  logic [31:0] wb_badv;

  lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_memop(ex_memop), .ex_addr(ex_addr), .ex_aluout(ex_aluout),
    .ex_wdata(ex_wdata), .ex_rd(ex_rd), .ex_we(ex_we), .flush(flush),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .wb_valid(wb_valid), .wb_result(wb_result),
    .wb_rd(wb_rd), .wb_we(wb_we), .wb_ale(wb_ale), .wb_badv(wb_badv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        we;
    logic        ale;
    logic [31:0] badv;
  } wb_t;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          d_addr;
    int          d_data;
  } bus_t;

  wb_t  wb_q[$];
  bus_t bus_q[$];
  bit   auto_bus = 1'b1;

  // Reference model: access width in bytes, 0 for a non-memory op.
  function automatic int unsigned nbytes(mem_op_t op);
    case (op)
      LD_B, LD_BU, ST_B: return 1;
      LD_H, LD_HU, ST_H: return 2;
      LD_W, ST_W:        return 4;
      default:           return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(mem_op_t op, logic [31:0] addr, logic [31:0] rdata);
    int unsigned       n   = nbytes(op);
    longint unsigned   r   = rdata;
    longint unsigned   v;
    longint            sv;
    v  = (r >> (8 * (addr % 4))) % (64'd1 << (8 * n));
    sv = v;
    if ((op == LD_B || op == LD_H) && v >= (64'd1 << (8 * n - 1)))
      sv = v - (64'd1 << (8 * n));
    return sv[31:0];
  endfunction

  function automatic logic [31:0] ref_wdata(int unsigned n, logic [31:0] w);
    logic [31:0] o;
    for (int i = 0; i < 4; i++) o[8*i +: 8] = w[8*(i % n) +: 8];
    return o;
  endfunction

  task automatic issue(mem_op_t op, logic [31:0] addr, logic [31:0] aluout,
                       logic [31:0] wdata, logic [4:0] rd, logic we,
                       logic [31:0] rdata, int da, int dd, bit track);
    int   n = 0;
    int unsigned nb;
    wb_t  e;
    bus_t b;
    while (!ex_ready) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        chk1("ex_ready_timeout", 1'b0, 1'b1);
        return;
      end
    end
    ex_memop = op; ex_addr = addr; ex_aluout = aluout; ex_wdata = wdata;
    ex_rd = rd; ex_we = we; ex_valid = 1'b1;
    if (track) begin
      nb = nbytes(op);
      e.rd = rd; e.result = '0; e.we = 1'b0; e.ale = 1'b0; e.badv = '0;
      if (nb == 0) begin
        e.result = aluout; e.we = we;
      end else if ((addr % nb) != 0) begin
        e.ale = 1'b1; e.badv = addr;
      end else begin
        b.addr   = addr;
        b.wr     = (op == ST_B || op == ST_H || op == ST_W);
        b.size   = (nb == 1) ? 2'd0 : (nb == 2) ? 2'd1 : 2'd2;
        b.wstrb  = 4'(((1 << nb) - 1) << (addr % 4));
        b.wdata  = ref_wdata(nb, wdata);
        b.rdata  = rdata;
        b.d_addr = da;
        b.d_data = dd;
        bus_q.push_back(b);
        if (!b.wr) begin
          e.result = ref_load(op, addr, rdata); e.we = we;
        end
      end
      wb_q.push_back(e);
    end
    @(negedge clk);
    ex_valid = 1'b0;
  endtask

  // Monitor: every write-back pulse must match the oldest expectation.
  initial begin
    wb_t e;
    forever begin
      @(negedge clk);
      if (reset && wb_valid) begin
        if (wb_q.size() == 0) begin
          chk1("wb_unexpected", wb_valid, 1'b0);
        end else begin
          e = wb_q.pop_front();
          chk("wb_result", wb_result, e.result);
          chk("wb_rd", 32'(wb_rd), 32'(e.rd));
          chk1("wb_we", wb_we, e.we);
          chk1("wb_ale", wb_ale, e.ale);
          chk("wb_badv", wb_badv, e.badv);
        end
      end
    end
  end

  // Bus responder: checks each request and answers with the planned timing.
  initial begin
    bus_t e;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = '0;
    forever begin
      @(negedge clk);
      if (auto_bus && reset && data_req) begin
        if (bus_q.size() == 0) begin
          chk1("bus_unexpected_req", data_req, 1'b0);
          e.addr = data_addr; e.rdata = '0; e.d_addr = 0; e.d_data = 0;
        end else begin
          e = bus_q.pop_front();
          chk("req_addr", data_addr, e.addr);
          chk1("req_wr", data_wr, e.wr);
          chk("req_size", 32'(data_size), 32'(e.size));
          if (e.wr) begin
            chk("req_wstrb", 32'(data_wstrb), 32'(e.wstrb));
            chk("req_wdata", data_wdata, e.wdata);
          end
        end
        for (int i = 0; i < e.d_addr; i++) begin
          @(negedge clk);
          chk1("req_held", data_req, 1'b1);
          chk("req_addr_held", data_addr, e.addr);
        end
        data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        chk1("req_dropped", data_req, 1'b0);
        repeat (e.d_data) @(negedge clk);
        data_rdata   = e.rdata;
        data_data_ok = 1'b1;
        @(negedge clk);
        data_data_ok = 1'b0;
        data_rdata   = $urandom;
      end
    end
  end

  initial begin
    int c0;
    int n;
    mem_op_t op;
    logic [31:0] a;
    reset = 1'b0; ex_valid = 1'b0; ex_memop = '0; ex_addr = '0; ex_aluout = '0;
    ex_wdata = '0; ex_rd = '0; ex_we = 1'b0; flush = 1'b0;

    repeat (3) @(negedge clk);
    chk1("rst_ex_ready", ex_ready, 1'b1);
    chk1("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_result", wb_result, 32'h0);
    chk1("rst_data_req", data_req, 1'b0);
    chk("rst_data_addr", data_addr, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Pass-through and back-to-back throughput
    issue(NONE, 32'h0, 32'h1234_5678, 32'h0, 5'd3, 1'b1, 32'h0, 0, 0, 1'b1);
    c0 = cyc;
    for (int i = 0; i < 4; i++)
      issue(NONE, 32'h0, 32'hA000_0000 + 32'(i), 32'h0, 5'(i + 4), 1'b1, 32'h0, 0, 0, 1'b1);
    chk("b2b_cycles", 32'(cyc - c0), 32'd4);
    @(negedge clk);
    chk("b2b_drained", 32'(wb_q.size()), 32'd0);

    // Directed memory cases
    issue(LD_B,  32'h1003, 32'h0, 32'h0, 5'd5, 1'b1, 32'h80FF_FFFF, 2, 0, 1'b1);
    issue(LD_BU, 32'h1003, 32'h0, 32'h0, 5'd6, 1'b1, 32'h80FF_FFFF, 2, 1, 1'b1);
    issue(ST_H,  32'h2002, 32'h0, 32'hAAAA_BEEF, 5'd7, 1'b1, 32'h0, 0, 1, 1'b1);
    issue(LD_W,  32'h3001, 32'h0, 32'h0, 5'd8, 1'b1, 32'h0, 0, 0, 1'b1);
    issue(LD_H,  32'h3002, 32'h0, 32'h0, 5'd9, 1'b1, 32'h1234_8001, 0, 0, 1'b1);
    issue(ST_B,  32'h3003, 32'h0, 32'h0000_005A, 5'd10, 1'b1, 32'h0, 1, 2, 1'b1);
    issue(ST_W,  32'h3004, 32'h0, 32'hDEAD_BEEF, 5'd11, 1'b1, 32'h0, 0, 0, 1'b1);
    n = 0;
    while (!ex_ready && n < 50) begin @(negedge clk); n++; end

    // Flush cases with the bus driven by hand
    auto_bus = 1'b0;
    issue(LD_W, 32'h5000, 32'h0, 32'h0, 5'd12, 1'b1, 32'h0, 0, 0, 1'b0);
    data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk1("discard_ready", ex_ready, 1'b0);
    chk1("discard_req", data_req, 1'b0);
    repeat (2) @(negedge clk);
    chk1("discard_ready_hold", ex_ready, 1'b0);
    data_rdata = 32'h1111_2222;
    data_data_ok = 1'b1;
    @(negedge clk);
    data_data_ok = 1'b0;
    chk1("discard_done_ready", ex_ready, 1'b1);

    issue(LD_W, 32'h5004, 32'h0, 32'h0, 5'd13, 1'b1, 32'h0, 0, 0, 1'b0);
    chk1("req_flush_pre", data_req, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk1("req_flush_drop", data_req, 1'b0);
    chk1("req_flush_ready", ex_ready, 1'b1);

    issue(LD_H, 32'h5008, 32'h0, 32'h0, 5'd14, 1'b1, 32'h0, 0, 0, 1'b0);
    data_addr_ok = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0;
    flush = 1'b0;
    chk1("req_ok_flush_ready", ex_ready, 1'b0);
    data_data_ok = 1'b1;
    @(negedge clk);
    data_data_ok = 1'b0;
    chk1("req_ok_flush_done", ex_ready, 1'b1);

    ex_memop = NONE; ex_aluout = 32'h7777_7777; ex_rd = 5'd15; ex_we = 1'b1;
    ex_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk1("idle_flush_no_wb", wb_valid, 1'b0);

    // Asynchronous reset while a request is outstanding
    issue(LD_W, 32'h6000, 32'h0, 32'h0, 5'd16, 1'b1, 32'h0, 0, 0, 1'b0);
    chk1("rst_mid_pre", data_req, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk1("rst_mid_req", data_req, 1'b0);
    chk1("rst_mid_ready", ex_ready, 1'b1);
    chk1("rst_mid_wb_valid", wb_valid, 1'b0);
    chk("rst_mid_addr", data_addr, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    auto_bus = 1'b1;
    issue(LD_W, 32'h6004, 32'h0, 32'h0, 5'd17, 1'b1, 32'hCAFE_F00D, 1, 1, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      op = mem_op_t'($urandom_range(0, 8));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0 && nbytes(op) != 0)
        a = a - (a % nbytes(op));
      issue(op, a, $urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            $urandom, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b1);
    end

    n = 0;
    while ((wb_q.size() != 0 || bus_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("final_wb_pending", 32'(wb_q.size()), 32'd0);
    chk("final_bus_pending", 32'(bus_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
